ex_stage: RTL

- Execute stage of the 16-bit pipelined processor. Sits between the ID/EX register and the memory stage.
- Selects forwarded operands and evaluates the ALU, including an iterative multi-cycle multiply.
- Drives the EX/MEM pipeline register consumed by the memory stage: PC, ALU result, store data, imm8, rs, dest reg, controls.
- Asserts a stall request to the hazard unit while a multiply is in flight.

---
 rtl/ex_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 16-bit pipeline. It selects forwarded operands, evaluates the ALU
// (MUL is an iterative shift-add), and drives the EX/MEM pipeline register.
module ex_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM8_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] rd1E_i,
  input  logic [DATA_WIDTH-1:0] rd2E_i,
  input  logic [IMM8_WIDTH-1:0] imm8E_i,
  input  logic [REG_WIDTH-1:0]  rsE_i,
  input  logic [REG_WIDTH-1:0]  WriteRegE_i,
  input  logic [OP_WIDTH-1:0]   AluOpE_i,
  input  logic                  AluSrcE_i,
  input  logic                  RegWriteE_i,
  input  logic                  BranchE_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic                  MemToRegE_i,
  input  logic                  MovE_i,
  input  logic [1:0]            ForwardAE_i,
  input  logic [1:0]            ForwardBE_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_fwd_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  stall_EX_MEM_i,
  input  logic                  flush_EX_MEM_i,
  output logic [ADDR_WIDTH-1:0] PCM_o,
  output logic [DATA_WIDTH-1:0] alu_outM_o,
  output logic [DATA_WIDTH-1:0] WriteDataM_o,
  output logic [IMM8_WIDTH-1:0] imm8M_o,
  output logic [REG_WIDTH-1:0]  rsM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  BranchM_o,
  output logic                  MemReadM_o,
  output logic                  MemWriteM_o,
  output logic                  MemToRegM_o,
  output logic                  MovM_o,
  output logic                  mul_stall_o
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(10);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  typedef struct packed {
    logic regWrite;
    logic branch;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic mov;
  } ctrl_t;

  mulState_t             state, stateNext;
  ctrl_t                 ctrlE, ctrlM;
  logic [DATA_WIDTH-1:0] srcA, fwdB, srcB, immExt, aluResult;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_WIDTH-1:0]  stepCnt;
  logic [3:0]            shamt;
  logic                  isMul;

  assign ctrlE  = {RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i};
  assign immExt = {{(DATA_WIDTH-IMM8_WIDTH){imm8E_i[IMM8_WIDTH-1]}}, imm8E_i};
  assign srcB   = AluSrcE_i ? immExt : fwdB;
  assign shamt  = srcB[3:0];
  assign isMul  = (AluOpE_i == OP_MUL);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    srcA = rd1E_i;
    fwdB = rd2E_i;
    case (ForwardAE_i)
      2'b01:   srcA = ResultW_i;
      2'b10:   srcA = alu_outM_fwd_i;
      default: srcA = rd1E_i;
    endcase
    case (ForwardBE_i)
      2'b01:   fwdB = ResultW_i;
      2'b10:   fwdB = alu_outM_fwd_i;
      default: fwdB = rd2E_i;
    endcase
  end

  always_comb begin
    aluResult = srcB;
    case (AluOpE_i)
      OP_ADD:  aluResult = srcA + srcB;
      OP_SUB:  aluResult = srcA - srcB;
      OP_AND:  aluResult = srcA & srcB;
      OP_OR:   aluResult = srcA | srcB;
      OP_XOR:  aluResult = srcA ^ srcB;
      OP_NOT:  aluResult = ~srcA;
      OP_SLL:  aluResult = srcA << shamt;
      OP_SRL:  aluResult = srcA >> shamt;
      OP_SRA:  aluResult = $unsigned($signed(srcA) >>> shamt);
      OP_MUL:  aluResult = acc;
      OP_SLT:  aluResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: aluResult = srcB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst || flush_EX_MEM_i) state <= IDLE;
    else if (!stall_EX_MEM_i)   state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    mul_stall_o = 1'b0;
    case (state)
      IDLE: if (isMul && !flush_EX_MEM_i) begin
        stateNext   = BUSY;
        mul_stall_o = 1'b1;
      end
      BUSY: begin
        mul_stall_o = 1'b1;
        if (stepCnt == LAST_STEP) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operands are captured at start, so forwarding changes while BUSY are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      stepCnt <= '0;
    end else if (!stall_EX_MEM_i && !flush_EX_MEM_i) begin
      if (state == IDLE && isMul) begin
        mcand   <= srcA;
        mplier  <= srcB;
        acc     <= '0;
        stepCnt <= '0;
      end else if (state == BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        stepCnt <= stepCnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_EX_MEM_i) begin
      PCM_o        <= '0;
      alu_outM_o   <= '0;
      WriteDataM_o <= '0;
      imm8M_o      <= '0;
      rsM_o        <= '0;
      WriteRegM_o  <= '0;
      ctrlM        <= '0;
    end else if (!stall_EX_MEM_i) begin
      if (mul_stall_o) begin
        ctrlM <= '0;
      end else begin
        PCM_o        <= PCE_i;
        alu_outM_o   <= aluResult;
        WriteDataM_o <= fwdB;
        imm8M_o      <= imm8E_i;
        rsM_o        <= rsE_i;
        WriteRegM_o  <= WriteRegE_i;
        ctrlM        <= ctrlE;
      end
    end
  end

  assign RegWriteM_o = ctrlM.regWrite;
  assign BranchM_o   = ctrlM.branch;
  assign MemReadM_o  = ctrlM.memRead;
  assign MemWriteM_o = ctrlM.memWrite;
  assign MemToRegM_o = ctrlM.memToReg;
  assign MovM_o      = ctrlM.mov;

endmodule
